// File: rtl/psram_arb_pkg.sv
// Shared types for the PSRAM port arbiter.
package psram_arb_pkg;

    typedef enum logic [1:0] {
        ARB,
        ISSUE,
        WAIT_RD
    } arb_state_t;

    typedef enum logic {
        RD,
        WR
    } arb_op_t;

endpackage

// File: rtl/psram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned W = $clog2(N);

    int unsigned pos;

    // Scan N positions starting at ptr; the modulo makes non-power-of-2 N wrap correctly.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(ptr) + k) % N;
            if (!found && req[W'(pos)]) begin
                found = 1'b1;
                idx   = W'(pos);
            end
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one psram read/write port pair between CLIENTS requesters.
module psram_arbiter
    import psram_arb_pkg::*;
#(
    parameter int unsigned CLIENTS      = 4,
    parameter int unsigned ADDRESS_BITS = 23,
    parameter int unsigned DATA_BITS    = 16,
    parameter int unsigned RD_LATENCY   = 4,
    parameter bit          WRITE_WINS   = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [CLIENTS-1:0]                c_rd_en,
    input  logic [CLIENTS*ADDRESS_BITS-1:0]   c_rd_address,
    output logic [CLIENTS-1:0]                c_rd_ack,
    output logic [CLIENTS-1:0]                c_rd_valid,
    output logic [DATA_BITS-1:0]              c_rd_data,
    input  logic [CLIENTS-1:0]                c_wr_en,
    input  logic [CLIENTS*ADDRESS_BITS-1:0]   c_wr_address,
    input  logic [CLIENTS*DATA_BITS-1:0]      c_wr_data,
    output logic [CLIENTS-1:0]                c_wr_ack,
    output logic                              mem_rd_en,
    output logic [ADDRESS_BITS-1:0]           mem_rd_address,
    input  logic                              mem_rd_ack,
    input  logic [DATA_BITS-1:0]              mem_rd_data,
    output logic                              mem_wr_en,
    output logic [ADDRESS_BITS-1:0]           mem_wr_address,
    output logic [DATA_BITS-1:0]              mem_wr_data,
    input  logic                              mem_wr_ack
);

    localparam int unsigned GW = $clog2(CLIENTS);
    localparam int unsigned CW = $clog2(RD_LATENCY + 1);
    localparam logic [GW-1:0] LAST_CLIENT = GW'(CLIENTS - 1);
    localparam logic [CW-1:0] CNT_DONE    = CW'(RD_LATENCY);

    arb_state_t         state, state_n;
    arb_op_t            op, op_n;
    logic [GW-1:0]      rr_ptr, rr_ptr_n;
    logic [GW-1:0]      grant, grant_n;
    logic [GW-1:0]      grant_inc;
    logic [CW-1:0]      cnt, cnt_n;
    logic [CLIENTS-1:0] req;
    logic               pick_found;
    logic [GW-1:0]      pick_idx;

    assign req = c_rd_en | c_wr_en;

    rr_pick #(
        .N (CLIENTS)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign grant_inc = (grant == LAST_CLIENT) ? '0 : grant + GW'(1);

    // State, pointer, grant, op and latency counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ARB;
            op     <= RD;
            rr_ptr <= '0;
            grant  <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            op     <= op_n;
            rr_ptr <= rr_ptr_n;
            grant  <= grant_n;
            cnt    <= cnt_n;
        end
    end

    // Address and write data always follow the granted client.
    always_comb begin
        mem_rd_address = '0;
        mem_wr_address = '0;
        mem_wr_data    = '0;
        for (int unsigned i = 0; i < CLIENTS; i++) begin
            if (grant == GW'(i)) begin
                mem_rd_address = c_rd_address[i*ADDRESS_BITS +: ADDRESS_BITS];
                mem_wr_address = c_wr_address[i*ADDRESS_BITS +: ADDRESS_BITS];
                mem_wr_data    = c_wr_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign c_rd_data = mem_rd_data;

    // Next-state logic plus memory enables and client strobes.
    always_comb begin
        state_n    = state;
        op_n       = op;
        rr_ptr_n   = rr_ptr;
        grant_n    = grant;
        cnt_n      = cnt;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        c_rd_ack   = '0;
        c_wr_ack   = '0;
        c_rd_valid = '0;

        case (state)
            ARB: begin
                if (pick_found) begin
                    grant_n = pick_idx;
                    if (c_wr_en[pick_idx] && (!c_rd_en[pick_idx] || WRITE_WINS)) begin
                        op_n = WR;
                    end else begin
                        op_n = RD;
                    end
                    state_n = ISSUE;
                end
            end

            ISSUE: begin
                mem_wr_en = (op == WR) && c_wr_en[grant];
                mem_rd_en = (op == RD) && c_rd_en[grant];
                c_wr_ack[grant] = mem_wr_en && mem_wr_ack;
                c_rd_ack[grant] = mem_rd_en && mem_rd_ack;
                if (mem_wr_en) begin
                    if (mem_wr_ack) begin
                        rr_ptr_n = grant_inc;
                        state_n  = ARB;
                    end
                end else if (mem_rd_en) begin
                    if (mem_rd_ack) begin
                        rr_ptr_n = grant_inc;
                        cnt_n    = CW'(1);
                        state_n  = WAIT_RD;
                    end
                end else begin
                    // Client withdrew its request before the controller accepted it.
                    state_n = ARB;
                end
            end

            WAIT_RD: begin
                cnt_n = cnt + CW'(1);
                if (cnt == CNT_DONE) begin
                    c_rd_valid[grant] = 1'b1;
                    state_n           = ARB;
                end
            end

            default: state_n = ARB;
        endcase

        // Registers may still hold a stale state while reset is asserted.
        if (reset) begin
            mem_rd_en  = 1'b0;
            mem_wr_en  = 1'b0;
            c_rd_ack   = '0;
            c_wr_ack   = '0;
            c_rd_valid = '0;
        end
    end

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter with a transaction-level reference model.
module tb_psram_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 23;
    localparam int unsigned DW = 16;
    localparam int unsigned L  = 4;
    localparam bit          WW = 1'b1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [N-1:0]    c_rd_en, c_wr_en;
    logic [N*AW-1:0] c_rd_address, c_wr_address;
    logic [N*DW-1:0] c_wr_data;
    wire  [N-1:0]    c_rd_ack, c_rd_valid, c_wr_ack;
    wire  [DW-1:0]   c_rd_data;
    wire             mem_rd_en, mem_wr_en;
    wire  [AW-1:0]   mem_rd_address, mem_wr_address;
    wire  [DW-1:0]   mem_wr_data;
    logic            mem_rd_ack, mem_wr_ack;
    logic [DW-1:0]   mem_rd_data;

    // second instance, read-wins variant, with an always-ready controller
    logic [N-1:0]    b_rd_en, b_wr_en;
    wire  [N-1:0]    b_c_rd_ack, b_c_rd_valid, b_c_wr_ack;
    wire  [DW-1:0]   b_c_rd_data;
    wire             b_mem_rd_en, b_mem_wr_en;
    wire  [AW-1:0]   b_mem_rd_address, b_mem_wr_address;
    wire  [DW-1:0]   b_mem_wr_data;
    wire             b_mem_rd_ack, b_mem_wr_ack;
    wire  [DW-1:0]   b_mem_rd_data;

    int cyc = 0;
    int busy_until = 0;
    int n_checks = 0;
    int n_fail = 0;

    int ack_cl[$], ack_wr[$], ack_cyc[$];
    int val_cl[$], val_cyc[$], val_data[$];
    int b_ack_wr[$];

    psram_arbiter #(
        .CLIENTS(N), .ADDRESS_BITS(AW), .DATA_BITS(DW), .RD_LATENCY(L), .WRITE_WINS(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .c_rd_en(c_rd_en), .c_rd_address(c_rd_address), .c_rd_ack(c_rd_ack),
        .c_rd_valid(c_rd_valid), .c_rd_data(c_rd_data),
        .c_wr_en(c_wr_en), .c_wr_address(c_wr_address), .c_wr_data(c_wr_data), .c_wr_ack(c_wr_ack),
        .mem_rd_en(mem_rd_en), .mem_rd_address(mem_rd_address), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_address(mem_wr_address),
        .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack)
    );

    psram_arbiter #(
        .CLIENTS(N), .ADDRESS_BITS(AW), .DATA_BITS(DW), .RD_LATENCY(L), .WRITE_WINS(1'b0)
    ) dut_rd_wins (
        .clk(clk), .reset(reset),
        .c_rd_en(b_rd_en), .c_rd_address(c_rd_address), .c_rd_ack(b_c_rd_ack),
        .c_rd_valid(b_c_rd_valid), .c_rd_data(b_c_rd_data),
        .c_wr_en(b_wr_en), .c_wr_address(c_wr_address), .c_wr_data(c_wr_data), .c_wr_ack(b_c_wr_ack),
        .mem_rd_en(b_mem_rd_en), .mem_rd_address(b_mem_rd_address), .mem_rd_ack(b_mem_rd_ack),
        .mem_rd_data(b_mem_rd_data), .mem_wr_en(b_mem_wr_en), .mem_wr_address(b_mem_wr_address),
        .mem_wr_data(b_mem_wr_data), .mem_wr_ack(b_mem_wr_ack)
    );

    assign b_mem_rd_ack  = b_mem_rd_en;
    assign b_mem_wr_ack  = b_mem_wr_en;
    assign b_mem_rd_data = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_value(input logic [AW-1:0] a);
        if (a == 23'h12345) return 16'hBEEF;
        return a[DW-1:0] ^ 16'hA5A5;
    endfunction

    function automatic logic [AW-1:0] rd_addr_of(input int i);
        return c_rd_address[i*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] wr_addr_of(input int i);
        return c_wr_address[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] wr_data_of(input int i);
        return c_wr_data[i*DW +: DW];
    endfunction

    // Controller model: accepts whenever not held busy; read data is valid exactly L cycles after the ack.
    assign mem_wr_ack = mem_wr_en && (cyc >= busy_until);
    assign mem_rd_ack = mem_rd_en && (cyc >= busy_until);

    logic [AW-1:0] rd_addr_q = '0;
    int rd_age = 0;
    always @(posedge clk) begin
        if (mem_rd_en && mem_rd_ack) begin
            rd_addr_q <= mem_rd_address;
            rd_age    <= 1;
        end else if (rd_age > 0) begin
            rd_age <= rd_age + 1;
        end
    end
    assign mem_rd_data = (rd_age == int'(L)) ? mem_value(rd_addr_q) : 16'hDEAD;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: one outstanding transaction, round-robin from the slot after the last accepted client.
    int m_owner = -1;
    bit m_wr = 1'b0;
    int m_ret = 0;
    int m_ret_owner = 0;
    int m_rr = 0;
    logic [AW-1:0] m_ret_addr = '0;

    always @(negedge clk) begin : cmp
        logic [N-1:0] e_rack, e_wack, e_val;
        logic e_ren, e_wen;
        int o, c;
        e_rack = '0; e_wack = '0; e_val = '0;
        e_ren = 1'b0; e_wen = 1'b0;
        o = -1; c = 0;
        if (reset) begin
            m_owner = -1; m_ret = 0; m_rr = 0;
        end else if (m_ret > 0) begin
            m_ret--;
            if (m_ret == 0) e_val[m_ret_owner] = 1'b1;
        end else if (m_owner >= 0) begin
            o = m_owner;
            m_owner = -1;
            if (m_wr ? c_wr_en[o] : c_rd_en[o]) begin
                if (m_wr) e_wen = 1'b1; else e_ren = 1'b1;
                if (cyc >= busy_until) begin
                    m_rr = (o + 1) % N;
                    if (m_wr) begin
                        e_wack[o] = 1'b1;
                    end else begin
                        e_rack[o] = 1'b1;
                        m_ret = L; m_ret_owner = o; m_ret_addr = rd_addr_of(o);
                    end
                end else begin
                    m_owner = o;
                end
            end
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                c = (m_rr + k) % N;
                if (m_owner < 0 && (c_rd_en[c] || c_wr_en[c])) begin
                    m_owner = c;
                    m_wr = c_wr_en[c] && (!c_rd_en[c] || WW);
                end
            end
        end

        chk("c_rd_ack", int'(c_rd_ack), int'(e_rack));
        chk("c_wr_ack", int'(c_wr_ack), int'(e_wack));
        chk("c_rd_valid", int'(c_rd_valid), int'(e_val));
        chk("mem_rd_en", int'(mem_rd_en), int'(e_ren));
        chk("mem_wr_en", int'(mem_wr_en), int'(e_wen));
        if (e_val != '0) chk("c_rd_data", int'(c_rd_data), int'(mem_value(m_ret_addr)));
        if (e_ren) chk("mem_rd_address", int'(mem_rd_address), int'(rd_addr_of(o)));
        if (e_wen) begin
            chk("mem_wr_address", int'(mem_wr_address), int'(wr_addr_of(o)));
            chk("mem_wr_data", int'(mem_wr_data), int'(wr_data_of(o)));
        end

        for (int i = 0; i < int'(N); i++) begin
            if (c_wr_ack[i]) begin ack_cl.push_back(i); ack_wr.push_back(1); ack_cyc.push_back(cyc); end
            if (c_rd_ack[i]) begin ack_cl.push_back(i); ack_wr.push_back(0); ack_cyc.push_back(cyc); end
            if (c_rd_valid[i]) begin val_cl.push_back(i); val_cyc.push_back(cyc); val_data.push_back(int'(c_rd_data)); end
            if (b_c_wr_ack[i]) b_ack_wr.push_back(1);
            if (b_c_rd_ack[i]) b_ack_wr.push_back(0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int qsize(input int which);
        case (which)
            0: return ack_cl.size();
            1: return val_cl.size();
            default: return b_ack_wr.size();
        endcase
    endfunction

    function automatic int q_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic wait_q(input int which, input int n, input int budget, input string name);
        int k;
        k = 0;
        while (qsize(which) < n && k < budget) begin
            tick(1);
            k++;
        end
        chk(name, qsize(which), n);
    endtask

    task automatic clear_logs();
        ack_cl.delete(); ack_wr.delete(); ack_cyc.delete();
        val_cl.delete(); val_cyc.delete(); val_data.delete();
        b_ack_wr.delete();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
    endtask

    initial begin : stim
        int t0;
        int exp_order[6] = '{0, 1, 3, 0, 1, 3};
        int n2;
        c_rd_en = '0; c_wr_en = '0; b_rd_en = '0; b_wr_en = '0;
        for (int i = 0; i < int'(N); i++) begin
            c_rd_address[i*AW +: AW] = AW'(32'h10000 + i * 32'h101);
            c_wr_address[i*AW +: AW] = AW'(32'h20000 + i * 32'h202);
            c_wr_data[i*DW +: DW]    = DW'(32'h1055 + i * 32'h1000);
        end

        // Reset with every client requesting both directions
        c_rd_en = '1; c_wr_en = '1;
        reset = 1'b1;
        clear_logs();
        tick(3);
        chk("reset_no_ack", ack_cl.size(), 0);
        reset = 1'b0;
        t0 = cyc;
        wait_q(0, 1, 20, "reset_first_ack_timeout");
        c_rd_en = '0; c_wr_en = '0;
        chk("reset_first_grant", q_at(ack_cl, 0), 0);
        chk("reset_first_is_wr", q_at(ack_wr, 0), 1);
        chk("reset_first_latency", q_at(ack_cyc, 0) - t0, 1);
        tick(10);

        // Single read from client 2, idle controller
        clear_logs();
        c_rd_address[2*AW +: AW] = 23'h12345;
        c_rd_en[2] = 1'b1;
        t0 = cyc;
        wait_q(0, 1, 20, "read_ack_timeout");
        c_rd_en[2] = 1'b0;
        wait_q(1, 1, 20, "read_valid_timeout");
        tick(3);
        chk("read_ack_client", q_at(ack_cl, 0), 2);
        chk("read_ack_is_rd", q_at(ack_wr, 0), 0);
        chk("read_ack_latency", q_at(ack_cyc, 0) - t0, 1);
        chk("read_valid_client", q_at(val_cl, 0), 2);
        chk("read_valid_latency", q_at(val_cyc, 0) - q_at(ack_cyc, 0), 4);
        chk("read_data", q_at(val_data, 0), 32'hBEEF);
        chk("read_single_valid", val_cl.size(), 1);

        // Fairness: clients 0, 1, 3 write continuously
        do_reset(2);
        clear_logs();
        c_wr_en = 4'b1011;
        wait_q(0, 6, 60, "fair_timeout");
        c_wr_en = '0;
        tick(4);
        for (int i = 0; i < 6; i++) chk($sformatf("fair_order_%0d", i), q_at(ack_cl, i), exp_order[i]);
        n2 = 0;
        foreach (ack_cl[i]) if (ack_cl[i] == 2) n2++;
        chk("fair_client2_never", n2, 0);
        chk("fair_spacing", q_at(ack_cyc, 1) - q_at(ack_cyc, 0), 2);

        // Same-client rd+wr conflict, write wins
        clear_logs();
        c_rd_en[1] = 1'b1; c_wr_en[1] = 1'b1;
        wait_q(0, 1, 20, "conf_first_timeout");
        c_wr_en[1] = 1'b0;
        wait_q(0, 2, 20, "conf_second_timeout");
        c_rd_en[1] = 1'b0;
        tick(8);
        chk("conf_first_client", q_at(ack_cl, 0), 1);
        chk("conf_first_is_wr", q_at(ack_wr, 0), 1);
        chk("conf_second_client", q_at(ack_cl, 1), 1);
        chk("conf_second_is_rd", q_at(ack_wr, 1), 0);
        chk("conf_valid_client", q_at(val_cl, 0), 1);

        // Same-client conflict on the read-wins instance
        b_rd_en[1] = 1'b1; b_wr_en[1] = 1'b1;
        wait_q(2, 1, 20, "rdwins_first_timeout");
        if (q_at(b_ack_wr, 0) == 0) b_rd_en[1] = 1'b0; else b_wr_en[1] = 1'b0;
        wait_q(2, 2, 20, "rdwins_second_timeout");
        b_rd_en = '0; b_wr_en = '0;
        chk("rdwins_first_is_rd", q_at(b_ack_wr, 0), 0);
        chk("rdwins_second_is_wr", q_at(b_ack_wr, 1), 1);
        tick(8);

        // Busy controller holds the write ack for 5 extra cycles
        clear_logs();
        t0 = cyc;
        busy_until = cyc + 6;
        c_wr_en[2] = 1'b1; c_wr_en[0] = 1'b1;
        wait_q(0, 1, 30, "busy_first_timeout");
        c_wr_en[2] = 1'b0;
        wait_q(0, 2, 20, "busy_second_timeout");
        c_wr_en = '0;
        tick(4);
        chk("busy_first_client", q_at(ack_cl, 0), 2);
        chk("busy_ack_delay", q_at(ack_cyc, 0) - t0, 6);
        chk("busy_second_client", q_at(ack_cl, 1), 0);
        chk("busy_second_spacing", q_at(ack_cyc, 1) - q_at(ack_cyc, 0), 2);
        chk("busy_ack_count", ack_cl.size(), 2);

        // Abort in ISSUE, then reset during WAIT_RD
        do_reset(2);
        clear_logs();
        busy_until = cyc + 1000;
        c_rd_en[0] = 1'b1;
        tick(2);
        c_rd_en[0] = 1'b0;
        tick(1);
        busy_until = 0;
        tick(2);
        chk("abort_no_ack", ack_cl.size(), 0);
        c_rd_en[0] = 1'b1; c_rd_en[1] = 1'b1;
        wait_q(0, 1, 20, "abort_next_timeout");
        chk("abort_ptr_kept", q_at(ack_cl, 0), 0);
        c_rd_en[0] = 1'b0;
        tick(1);
        reset = 1'b1;
        c_rd_en[0] = 1'b1;
        tick(1);
        reset = 1'b0;
        wait_q(0, 2, 20, "midread_restart_timeout");
        chk("midread_restart_client", q_at(ack_cl, 1), 0);
        chk("midread_no_stale_valid", val_cl.size(), 0);
        c_rd_en = '0;
        tick(10);
        chk("midread_valid_count", val_cl.size(), 1);
        chk("midread_valid_client", q_at(val_cl, 0), 0);
        chk("midread_valid_latency", q_at(val_cyc, 0) - q_at(ack_cyc, 1), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/psram_arbiter.md
# psram_arbiter

Round-robin arbiter that shares one `psram` controller port pair (read and write) between `CLIENTS` requesters such as the CPU, video scan-out and the loader. It sits between the clients and `psram`.
- Grants one transaction at a time.
- Forwards the controller's same-cycle acks to the granted client.
- Tracks the fixed read latency and returns read data to the issuing client with a one-cycle valid strobe.

## Interface
Parameters:
- `CLIENTS`, 4: number of requesters, 2..8.
- `ADDRESS_BITS`, 23: word address width, both banks included.
- `DATA_BITS`, 16: word width.
- `RD_LATENCY`, 4: cycles from `mem_rd_ack` to `mem_rd_data` stable; equals controller N+1.
- `WRITE_WINS`, 1: within one client, a write beats a simultaneous read.

Ports:
- `clk`  in  1: single clock, same clock as `psram`.
- `reset`  in  1: synchronous, active-high.
- `c_rd_en`  in  CLIENTS: per-client read request, level, held until ack.
- `c_rd_address`  in  CLIENTS×ADDRESS_BITS: per-client read address.
- `c_rd_ack`  out  CLIENTS: read accepted, one-hot pulse.
- `c_rd_valid`  out  CLIENTS: read data valid, one-hot pulse.
- `c_rd_data`  out  DATA_BITS: shared read data bus, qualified by `c_rd_valid`.
- `c_wr_en`  in  CLIENTS: per-client write request, level, held until ack.
- `c_wr_address`  in  CLIENTS×ADDRESS_BITS: per-client write address.
- `c_wr_data`  in  CLIENTS×DATA_BITS: per-client write data.
- `c_wr_ack`  out  CLIENTS: write accepted, one-hot pulse.
- `mem_rd_en`, `mem_rd_address`, `mem_rd_ack`, `mem_rd_data`, `mem_wr_en`, `mem_wr_address`, `mem_wr_data`, `mem_wr_ack`: these connect one-to-one to the `psram` ports of the same suffix. `mem_*_ack` and `mem_rd_data` are inputs; the others are outputs.

## Operation
- State machine with three states: `ARB`, `ISSUE`, `WAIT_RD`. Reset enters `ARB`.
- **ARB**
  - A client is eligible when its `c_rd_en` or `c_wr_en` is high.
  - Pick the first eligible client at or after `rr_ptr`, wrapping modulo CLIENTS.
  - Register `grant` and `op`:
    - if only one request is high, `op` is that request;
    - if both are high, `op` = WR when `WRITE_WINS`, else RD.
  - With no eligible client, stay in `ARB`.
- **ISSUE**
  - `mem_wr_en = (op==WR) & c_wr_en[grant]` and `mem_rd_en = (op==RD) & c_rd_en[grant]`.
  - Address and data are muxed combinationally from client `grant`.
  - `c_*_ack[grant] = mem_*_ack`, combinational passthrough.
  - On ack:
    - `rr_ptr <= grant+1`, wrapping modulo CLIENTS.
    - A WR ack goes to `ARB`.
    - A RD ack goes to `WAIT_RD` with `cnt <= 1`.
  - No ack: stay in `ISSUE`, because the controller is busy.
  - If the client drops its request before ack, return to `ARB` with no ack; `rr_ptr` is unchanged.
- **WAIT_RD**
  - `cnt` increments each cycle.
  - When `cnt == RD_LATENCY`: `c_rd_valid[grant]=1`, then go to `ARB`.
  - `c_rd_data = mem_rd_data` always, as a combinational passthrough.
- Only one transaction is in flight at any time. Per-client order is preserved.
- In `ARB`, no `mem_*_en` or client ack/valid is asserted.
- The `mem_*_address` and `mem_wr_data` outputs are don't-care outside `ISSUE`; drive client `grant`'s values.

## Timing
- Reset values: state `ARB`, `rr_ptr=0`, `grant=0`, `cnt=0`. All `c_*_ack`, `c_rd_valid` and `mem_*_en` are 0 while `reset` is high and in the cycle after.
- A request first seen in `ARB` at cycle t is issued at t+1. With the controller idle, the ack is at t+1 and `c_rd_valid` is at t+1+RD_LATENCY. The next `ARB` is at t+2 for writes and t+2+RD_LATENCY for reads.
- Back-to-back writes from one client give one ack every 2 cycles minimum. Actual spacing is set by the controller's busy period.
- Reset mid-read: the pending valid is discarded and no strobe is issued. The controller itself has no reset; `ISSUE` waits for its ack, so a controller still mid-cycle is never violated.
- `cnt` width is `$clog2(RD_LATENCY+1)`. `rr_ptr` and `grant` width is `$clog2(CLIENTS)`. Wrap is explicit for non-power-of-2 CLIENTS.

## Structure
- Package `psram_arb_pkg`: `arb_state_t` enum {ARB, ISSUE, WAIT_RD} and `arb_op_t` enum {RD, WR}.
- Sub-module `rr_pick`: combinational round-robin picker, parameter `N`. Inputs are the `req` vector and `ptr`; outputs are `found` and `idx`.
- Top level holds the FSM, the counter and the muxes.

## Test plan
- Reset: `reset` held 3 cycles with all clients requesting -> no ack/valid/en during reset or the next cycle; first grant goes to client 0.
- Single read: client 2 reads 0x12345 against a model returning 0xBEEF, controller idle -> `c_rd_ack[2]` 1 cycle after the request, `c_rd_valid[2]` with 0xBEEF 4 cycles after the ack, no other client bit set.
- Fairness: clients 0, 1 and 3 hold writes continuously -> ack order 0,1,3,0,1,3…; client 2 never acked.
- Same-client conflict: client 1 raises rd and wr together, `WRITE_WINS=1` -> write acked first, then read acked on the next grant to client 1. With `WRITE_WINS=0`, read first.
- Busy controller: the model withholds ack for 5 cycles -> arbiter stays in `ISSUE` with `mem_wr_en` high, and no other client is acked meanwhile.
- Abort and reset: client 0 drops `c_rd_en` while in `ISSUE` -> no ack and `rr_ptr` still 0. Then `reset` in `WAIT_RD` at cnt=2 -> no `c_rd_valid` ever, and arbitration restarts at client 0.
